// File: rtl/rv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the multicycle RV32 control path: opcode and funct
// constants, controller state encoding, immediate-format, ALU-operation and
// trap-cause encodings, and the instruction classifier. The immediate
// generator and datapath import the same package so encodings stay in sync.
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 (instruction[14:12]) and funct7 (instruction[31:25])
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [6:0] F7_SLLI = 7'b0000000;

    // Controller state encoding
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    // Immediate format select (1x is reserved)
    localparam logic [1:0] IMM_SEL_I = 2'b00;
    localparam logic [1:0] IMM_SEL_S = 2'b01;

    // ALU operation select
    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SLL = 2'b01;

    // Trap cause encoding
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Instruction class latched in DECODE and used by later states
    typedef enum logic [2:0] {
        CLS_ADDI    = 3'd0,
        CLS_SLLI    = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_ILLEGAL = 3'd4
    } inst_class_e;

    // Classify an instruction from its opcode/funct fields; anything outside
    // the supported subset is reported as illegal.
    function automatic inst_class_e decode_class(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic [6:0] funct7
    );
        inst_class_e cls;
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == F3_ADDI) begin
                    cls = CLS_ADDI;
                end else if ((funct3 == F3_SLLI) && (funct7 == F7_SLLI)) begin
                    cls = CLS_SLLI;
                end else begin
                    cls = CLS_ILLEGAL;
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_LW) begin
                    cls = CLS_LW;
                end else begin
                    cls = CLS_ILLEGAL;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_SW) begin
                    cls = CLS_SW;
                end else begin
                    cls = CLS_ILLEGAL;
                end
            end
            default: cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
// Counts cycles a memory request has been stalled and flags when the stall
// length reaches TIMEOUT.
//   clk       : clock
//   reset_n   : asynchronous active-low reset, clears the count
//   i_clear   : synchronous clear (takes priority over i_enable)
//   i_enable  : a stalled request cycle (request high, ready low)
//   o_expired : this stalled cycle is the TIMEOUT-th one
// TIMEOUT must be at least 1.
// -----------------------------------------------------------------------------
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Stall-cycle counter, saturating at TIMEOUT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(TIMEOUT))) begin
            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    // Expiry is flagged during the stalled cycle that brings the count to
    // TIMEOUT, so a ready arriving in that same cycle (which drops enable)
    // always wins over the trap.
    assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for a multicycle RV32 subset (ADDI, SLLI, LW, SW) with
// illegal-instruction and bus-timeout traps.
//   clk, reset_n      : clock, asynchronous active-low reset
//   instruction[31:0] : IR contents, stable from DECODE onward
//   mem_ready         : memory completes the current request this cycle
//   pc_write/ir_write : PC-update / IR-load strobes (FETCH completion)
//   mem_req/mem_we    : memory request / request is a write
//   imm_sel[1:0]      : immediate format (00 I, 01 S)
//   alu_src_imm       : ALU B operand is the immediate
//   alu_op[1:0]       : 00 add, 01 shift-left-logical
//   reg_write, wb_sel : register write strobe, writeback source (1 = load)
//   trap_cause[1:0]   : 00 none, 01 illegal, 10 bus timeout
//   retired[31:0]     : completed-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  imm_sel,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        wb_sel,
    output logic [1:0]  trap_cause,
    output logic [31:0] retired
);

    state_e      r_state;
    state_e      w_next_state;
    inst_class_e r_cls;
    inst_class_e w_dec_cls;
    inst_class_e w_cls_next;
    logic [1:0]  r_trap_cause;
    logic [1:0]  w_trap_next;
    logic [31:0] r_retired;
    logic        w_retire;

    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_alu_src_imm;
    logic [1:0]  r_imm_sel;
    logic [1:0]  r_alu_op;
    logic        r_reg_write;
    logic        r_wb_sel;

    logic        w_ready;
    logic        w_cnt_clear;
    logic        w_cnt_en;
    logic        w_expired;
    logic        w_unused_bits;

    // Register fields are the datapath's business, not the controller's
    assign w_unused_bits = ^{instruction[24:15], instruction[11:7]};

    assign w_dec_cls  = decode_class(instruction[6:0], instruction[14:12], instruction[31:25]);
    assign w_cls_next = (r_state == ST_DECODE) ? w_dec_cls : r_cls;

    // A ready only counts while a request is actually on the bus; this keeps
    // the FSM parked in FETCH during the first cycle after reset release.
    assign w_ready  = r_mem_req && mem_ready;
    assign w_cnt_en = r_mem_req && !mem_ready;

    // Restart the stall count whenever a new request phase begins
    assign w_cnt_clear = (w_next_state != r_state) &&
                         ((w_next_state == ST_FETCH) || (w_next_state == ST_MEM));

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .o_expired (w_expired)
    );

    // Next-state, trap-cause and retire decision
    always_comb begin
        w_next_state = r_state;
        w_trap_next  = r_trap_cause;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_ready) begin
                    w_next_state = ST_DECODE;
                end else if (w_expired) begin
                    w_next_state = ST_TRAP;
                    w_trap_next  = TRAP_TIMEOUT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (w_dec_cls == CLS_ILLEGAL) begin
                    w_next_state = ST_TRAP;
                    w_trap_next  = TRAP_ILLEGAL;
                end else begin
                    w_next_state = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if ((r_cls == CLS_LW) || (r_cls == CLS_SW)) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                if (w_ready) begin
                    if (r_cls == CLS_SW) begin
                        // A store completes here; it has no writeback
                        w_next_state = ST_FETCH;
                        w_retire     = 1'b1;
                    end else begin
                        w_next_state = ST_WRITEBACK;
                    end
                end else if (w_expired) begin
                    w_next_state = ST_TRAP;
                    w_trap_next  = TRAP_TIMEOUT;
                end else begin
                    w_next_state = ST_MEM;
                end
            end
            ST_WRITEBACK: begin
                w_next_state = ST_FETCH;
                w_retire     = 1'b1;
            end
            ST_TRAP: begin
                w_next_state = ST_TRAP;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // State, class, counters and registered Moore outputs. Outputs are
    // computed from the next state so they line up with the state register
    // and read as 0 while reset is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_FETCH;
            r_cls         <= CLS_ILLEGAL;
            r_trap_cause  <= TRAP_NONE;
            r_retired     <= 32'd0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_alu_src_imm <= 1'b0;
            r_imm_sel     <= IMM_SEL_I;
            r_alu_op      <= ALU_OP_ADD;
            r_reg_write   <= 1'b0;
            r_wb_sel      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cls        <= w_cls_next;
            r_trap_cause <= w_trap_next;
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end else begin
                r_retired <= r_retired;
            end
            r_mem_req     <= (w_next_state == ST_FETCH) || (w_next_state == ST_MEM);
            r_mem_we      <= (w_next_state == ST_MEM) && (w_cls_next == CLS_SW);
            r_alu_src_imm <= (w_next_state == ST_EXECUTE);
            r_imm_sel     <= ((w_next_state == ST_EXECUTE) && (w_cls_next == CLS_SW)) ?
                             IMM_SEL_S : IMM_SEL_I;
            r_alu_op      <= ((w_next_state == ST_EXECUTE) && (w_cls_next == CLS_SLLI)) ?
                             ALU_OP_SLL : ALU_OP_ADD;
            r_reg_write   <= (w_next_state == ST_WRITEBACK);
            r_wb_sel      <= (w_next_state == ST_WRITEBACK) && (w_cls_next == CLS_LW);
        end
    end

    // IR load and PC update happen in the cycle the fetch completes
    assign pc_write    = (r_state == ST_FETCH) && w_ready;
    assign ir_write    = (r_state == ST_FETCH) && w_ready;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign imm_sel     = r_imm_sel;
    assign alu_src_imm = r_alu_src_imm;
    assign alu_op      = r_alu_op;
    assign reg_write   = r_reg_write;
    assign wb_sel      = r_wb_sel;
    assign trap_cause  = r_trap_cause;
    assign retired     = r_retired;

endmodule
